// File: rtl/up_down_count_monitor.sv
// Observes an up/down counter on the fast clock. Recovers direction and step period,
// and flags illegal steps and stalls.
module up_down_count_monitor #(
  parameter int unsigned W       = 3,
  parameter int unsigned PW      = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned LOCK    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  count_in,
  output logic          dir,
  output logic          locked,
  output logic          step_strb,
  output logic          step_err,
  output logic [7:0]    err_cnt,
  output logic [PW-1:0] period,
  output logic          stall
);

  localparam int unsigned CW = (LOCK < 2) ? 1 : $clog2(LOCK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCKED
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cons, cons_next;
  logic          cons_dir, cons_dir_next;
  logic [W-1:0]  prev;
  logic [PW-1:0] gap;
  logic          have_ref;

  logic change, up_step, down_step, legal, step_dir, stall_hit;

  assign change    = (count_in != prev);
  assign up_step   = (count_in == prev + W'(1));
  assign down_step = (count_in == prev - W'(1));
  assign legal     = up_step || down_step;
  assign step_dir  = up_step;
  // A change on the edge where gap hits TIMEOUT wins over the stall.
  assign stall_hit = (state != S_IDLE) && !change && (gap == PW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cons     <= '0;
      cons_dir <= 1'b0;
    end else begin
      state    <= state_next;
      cons     <= cons_next;
      cons_dir <= cons_dir_next;
    end
  end

  always_comb begin
    state_next    = state;
    cons_next     = cons;
    cons_dir_next = cons_dir;
    case (state)
      S_IDLE: begin
        state_next = S_ACQ;
        cons_next  = '0;
      end
      default: begin
        if (change) begin
          if (!legal) begin
            state_next = S_ACQ;
            cons_next  = '0;
          end else begin
            cons_dir_next = step_dir;
            if (state == S_LOCKED) begin
              if (step_dir != dir) begin
                state_next = S_ACQ;
                cons_next  = CW'(1);
              end
            end else begin
              if ((cons != '0) && (cons_dir == step_dir))
                cons_next = cons + CW'(1);
              else
                cons_next = CW'(1);
              if (cons_next >= CW'(LOCK))
                state_next = S_LOCKED;
            end
          end
        end else if (stall_hit) begin
          state_next = S_ACQ;
          cons_next  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= '0;
      gap       <= '0;
      have_ref  <= 1'b0;
      dir       <= 1'b0;
      locked    <= 1'b0;
      step_strb <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      period    <= '0;
      stall     <= 1'b0;
    end else begin
      prev   <= count_in;
      locked <= (state_next == S_LOCKED);
      if (state_next == S_LOCKED)
        dir <= cons_dir_next;
      if (state == S_IDLE) begin
        gap       <= '0;
        have_ref  <= 1'b0;
        step_strb <= 1'b0;
        step_err  <= 1'b0;
      end else begin
        step_strb <= change;
        step_err  <= change && !legal;
        if (change) begin
          gap      <= PW'(1);
          have_ref <= 1'b1;
          stall    <= 1'b0;
          if (have_ref)
            period <= gap;
          if (!legal && (err_cnt != '1))
            err_cnt <= err_cnt + 8'd1;
        end else begin
          if (gap != '1)
            gap <= gap + PW'(1);
          if (stall_hit)
            stall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Directed bench for up_down_count_monitor: lock, reversal, illegal steps, stall,
// async reset and the change-on-timeout corner.
module tb_up_down_count_monitor;

  localparam int unsigned W  = 3;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  count_in = '0;
  logic          dir, locked, step_strb, step_err, stall;
  logic [7:0]    err_cnt;
  logic [PW-1:0] period;

  int n_checks = 0;
  int n_errors = 0;

  up_down_count_monitor #(
    .W(W), .PW(PW), .TIMEOUT(64), .LOCK(2)
  ) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .dir(dir), .locked(locked), .step_strb(step_strb), .step_err(step_err),
    .err_cnt(err_cnt), .period(period), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic step(input logic [W-1:0] v);
    count_in = v;
    tick();
  endtask

  // Finish an 8-cycle step slot, confirming the pulses lasted one cycle.
  task automatic settle();
    tick();
    check("strb_pulse", 32'(step_strb), 0);
    check("err_pulse", 32'(step_err), 0);
    hold(6);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dir"}, 32'(dir), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_strb"}, 32'(step_strb), 0);
    check({tag, "_err"}, 32'(step_err), 0);
    check({tag, "_errcnt"}, 32'(err_cnt), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_stall"}, 32'(stall), 0);
  endtask

  initial begin
    hold(3);
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check("prime_strb", 32'(step_strb), 0);
    check("prime_locked", 32'(locked), 0);
    hold(6);

    // Up count with wrap
    step(3'd1);
    check("up1_strb", 32'(step_strb), 1);
    check("up1_locked", 32'(locked), 0);
    check("up1_period", 32'(period), 0);
    settle();
    step(3'd2);
    check("up2_locked", 32'(locked), 1);
    check("up2_dir", 32'(dir), 1);
    check("up2_period", 32'(period), 8);
    settle();
    for (int v = 3; v <= 7; v++) begin
      step(3'(v));
      check("upn_locked", 32'(locked), 1);
      check("upn_period", 32'(period), 8);
      settle();
    end
    step(3'd0);
    check("wrap_strb", 32'(step_strb), 1);
    check("wrap_err", 32'(step_err), 0);
    check("wrap_locked", 32'(locked), 1);
    settle();
    step(3'd1);
    check("post_wrap_period", 32'(period), 8);
    settle();
    check("up_errcnt", 32'(err_cnt), 0);

    // Direction reversal
    step(3'd2);
    settle();
    step(3'd3);
    check("at3_locked", 32'(locked), 1);
    settle();
    step(3'd2);
    check("rev_locked", 32'(locked), 0);
    check("rev_dir_hold", 32'(dir), 1);
    check("rev_strb", 32'(step_strb), 1);
    settle();
    step(3'd1);
    check("relock_dn", 32'(locked), 1);
    check("relock_dir", 32'(dir), 0);
    settle();
    step(3'd0);
    settle();
    step(3'd7);
    check("dnwrap_strb", 32'(step_strb), 1);
    check("dnwrap_err", 32'(step_err), 0);
    check("dnwrap_locked", 32'(locked), 1);
    check("dnwrap_dir", 32'(dir), 0);
    settle();

    // Illegal jump
    for (int v = 6; v >= 3; v--) begin
      step(3'(v));
      settle();
    end
    step(3'd2);
    check("at2_locked", 32'(locked), 1);
    settle();
    step(3'd5);
    check("jump_err", 32'(step_err), 1);
    check("jump_strb", 32'(step_strb), 1);
    check("jump_errcnt", 32'(err_cnt), 1);
    check("jump_locked", 32'(locked), 0);
    settle();
    step(3'd6);
    check("jump_up1_locked", 32'(locked), 0);
    settle();
    step(3'd7);
    check("jump_up2_locked", 32'(locked), 1);
    check("jump_up2_dir", 32'(dir), 1);
    settle();
    for (int k = 1; k <= 300; k++) begin
      step((k % 2 == 1) ? 3'd1 : 3'd7);
      if (k == 100) check("sat_100", 32'(err_cnt), 101);
      if (k == 253) check("sat_253", 32'(err_cnt), 254);
      if (k == 254) check("sat_254", 32'(err_cnt), 255);
      if (k == 300) begin
        check("sat_300", 32'(err_cnt), 255);
        check("sat_err_pulse", 32'(step_err), 1);
        check("sat_period", 32'(period), 1);
      end
    end
    settle();

    // Stall
    step(3'd0);
    check("st_pre_locked", 32'(locked), 0);
    settle();
    step(3'd1);
    check("st_lock", 32'(locked), 1);
    hold(63);
    check("st_gap63_stall", 32'(stall), 0);
    check("st_gap63_locked", 32'(locked), 1);
    tick();
    check("st_stall", 32'(stall), 1);
    check("st_locked", 32'(locked), 0);
    hold(5);
    check("st_stall_held", 32'(stall), 1);
    step(3'd2);
    check("st_clear", 32'(stall), 0);
    check("st_clear_strb", 32'(step_strb), 1);
    check("st_clear_locked", 32'(locked), 0);
    check("st_clear_period", 32'(period), 70);
    settle();
    step(3'd3);
    check("st_relock", 32'(locked), 1);
    check("st_relock_dir", 32'(dir), 1);

    // Change landing exactly on the timeout edge
    hold(63);
    check("to_pre_stall", 32'(stall), 0);
    step(3'd4);
    check("to_stall", 32'(stall), 0);
    check("to_strb", 32'(step_strb), 1);
    check("to_period", 32'(period), 64);
    check("to_locked", 32'(locked), 1);

    // Async reset between edges
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("areset");
    count_in = 3'd5;
    hold(2);
    rst = 1'b1;
    tick();
    check("rel_prime_strb", 32'(step_strb), 0);
    check("rel_prime_period", 32'(period), 0);
    step(3'd6);
    check("rel_strb", 32'(step_strb), 1);
    check("rel_period", 32'(period), 0);
    check("rel_err", 32'(step_err), 0);
    check("rel_errcnt", 32'(err_cnt), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
